// File: rtl/pwm_mc_pkg.sv
// Shared types for the shadowed multi-channel PWM: channel mode, channel
// configuration record and the channel-index width helper.
package pwm_mc_pkg;

  localparam int COUNTER_WIDTH = 16;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  typedef struct packed {
    logic [COUNTER_WIDTH-1:0] period;
    logic [COUNTER_WIDTH-1:0] duty;
    pwm_mode_e                mode;
    logic                     enable;
  } pwm_ch_cfg_t;

  // A single channel still needs a one-bit index so the port never collapses.
  function automatic int ch_idx_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/pwm_mc_channel.sv
// One PWM channel: shadow/active configuration, pending flag, up/down counter,
// boundary detect and registered output. Optional irq port under PWM_IRQ_EN.
module pwm_mc_channel
  import pwm_mc_pkg::*;
#(
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [COUNTER_WIDTH-1:0] wr_period,
  input  logic [COUNTER_WIDTH-1:0] wr_duty,
  input  logic                     wr_mode,
  input  logic                     wr_enable,
  input  logic                     sync,
  output logic                     pending,
  output logic                     pwm
`ifdef PWM_IRQ_EN
  ,
  output logic                     irq
`endif
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = {COUNTER_WIDTH{1'b0}};
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1'b1);

  logic [COUNTER_WIDTH-1:0] shd_period_r;
  logic [COUNTER_WIDTH-1:0] shd_duty_r;
  pwm_mode_e                shd_mode_r;
  logic                     shd_enable_r;
  logic [COUNTER_WIDTH-1:0] act_period_r;
  logic [COUNTER_WIDTH-1:0] act_duty_r;
  pwm_mode_e                act_mode_r;
  logic                     act_enable_r;
  logic                     pending_r;
  logic [COUNTER_WIDTH-1:0] cnt_r;
  logic                     dir_down_r;
  logic                     pwm_r;

  logic [COUNTER_WIDTH-1:0] period_m1_s;
  logic                     bnd_s;
  logic                     restart_s;
  logic                     commit_s;
  logic [COUNTER_WIDTH-1:0] cnt_nxt_s;
  logic                     dir_nxt_s;
  logic                     pwm_nxt_s;

  assign period_m1_s = act_period_r - CNT_ONE;
  // A disabled channel, a boundary or a sync all restart the counter; a
  // pending shadow rides along on any of them.
  assign restart_s   = ~act_enable_r | bnd_s | sync;
  assign commit_s    = pending_r & restart_s;
  assign pending     = pending_r;
  assign pwm         = pwm_r;

  // Period boundary of the active configuration (every cycle when period is 0).
  always_comb begin
    bnd_s = 1'b0;
    if (!act_enable_r) begin
      bnd_s = 1'b0;
    end else if (act_period_r == CNT_ZERO) begin
      bnd_s = 1'b1;
    end else begin
      case (act_mode_r)
        PWM_EDGE:   bnd_s = (cnt_r == period_m1_s);
        PWM_CENTER: bnd_s = dir_down_r & (cnt_r == CNT_ZERO);
        default:    bnd_s = 1'b0;
      endcase
    end
  end

  // Counter next state; center mode holds each end value for two cycles.
  always_comb begin
    cnt_nxt_s = cnt_r;
    dir_nxt_s = dir_down_r;
    if (restart_s) begin
      cnt_nxt_s = CNT_ZERO;
      dir_nxt_s = 1'b0;
    end else begin
      case (act_mode_r)
        PWM_EDGE: begin
          cnt_nxt_s = cnt_r + CNT_ONE;
          dir_nxt_s = 1'b0;
        end
        PWM_CENTER: begin
          if (dir_down_r) begin
            cnt_nxt_s = cnt_r - CNT_ONE;
          end else if (cnt_r == period_m1_s) begin
            dir_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          cnt_nxt_s = CNT_ZERO;
          dir_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Output compare; period 0 and disabled force low.
  always_comb begin
    pwm_nxt_s = 1'b0;
    if (act_enable_r && (act_period_r != CNT_ZERO)) begin
      pwm_nxt_s = (cnt_r < act_duty_r);
    end else begin
      pwm_nxt_s = 1'b0;
    end
  end

  // Shadow capture of an accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_period_r <= CNT_ZERO;
      shd_duty_r   <= CNT_ZERO;
      shd_mode_r   <= PWM_EDGE;
      shd_enable_r <= 1'b0;
    end else if (wr_en) begin
      shd_period_r <= wr_period;
      shd_duty_r   <= wr_duty;
      shd_mode_r   <= pwm_mode_e'(wr_mode);
      shd_enable_r <= wr_enable;
    end
  end

  // Pending flag and shadow-to-active commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r    <= 1'b0;
      act_period_r <= CNT_ZERO;
      act_duty_r   <= CNT_ZERO;
      act_mode_r   <= PWM_EDGE;
      act_enable_r <= 1'b0;
    end else if (commit_s) begin
      pending_r    <= 1'b0;
      act_period_r <= shd_period_r;
      act_duty_r   <= shd_duty_r;
      act_mode_r   <= shd_mode_r;
      act_enable_r <= shd_enable_r;
    end else if (wr_en) begin
      pending_r    <= 1'b1;
    end
  end

  // Counter, direction and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= CNT_ZERO;
      dir_down_r <= 1'b0;
      pwm_r      <= 1'b0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      dir_down_r <= dir_nxt_s;
      pwm_r      <= pwm_nxt_s;
    end
  end

`ifdef PWM_IRQ_EN
  logic irq_r;

  assign irq = irq_r;

  // One-cycle pulse following each natural boundary of an enabled channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= bnd_s;
    end
  end
`endif

endmodule

// File: rtl/pwm_mc_shadowed.sv
// N-channel shadowed PWM top: config write decode, cfg_ready mux and sync
// fan-out. Define PWM_IRQ_EN to add the per-channel period-end irq_out port.
module pwm_mc_shadowed
  import pwm_mc_pkg::*;
#(
  parameter int NUM_CHANNELS  = 8,
  parameter int COUNTER_WIDTH = 16,
  parameter int CH_IDX_W      = ch_idx_w(NUM_CHANNELS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [CH_IDX_W-1:0]      cfg_ch,
  input  logic [COUNTER_WIDTH-1:0] cfg_period,
  input  logic [COUNTER_WIDTH-1:0] cfg_duty,
  input  logic                     cfg_mode,
  input  logic                     cfg_enable,
  input  logic                     sync_in,
  output logic [NUM_CHANNELS-1:0]  pwm_out
`ifdef PWM_IRQ_EN
  ,
  output logic [NUM_CHANNELS-1:0]  irq_out
`endif
);

  localparam int CH_SPAN = 32'd1 << CH_IDX_W;

  logic [NUM_CHANNELS-1:0] pending_s;
  logic [NUM_CHANNELS-1:0] wr_en_s;
  logic [CH_SPAN-1:0]      pend_ext_s;
  logic                    accept_s;

  // Unused channel indices read as never pending, so writes there are
  // accepted and silently dropped.
  always_comb begin
    pend_ext_s                   = {CH_SPAN{1'b0}};
    pend_ext_s[NUM_CHANNELS-1:0] = pending_s;
  end

  assign cfg_ready = ~pend_ext_s[cfg_ch];
  assign accept_s  = cfg_valid & cfg_ready;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    assign wr_en_s[g] = accept_s & (cfg_ch == CH_IDX_W'(g));

    pwm_mc_channel #(
      .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en_s[g]),
      .wr_period (cfg_period),
      .wr_duty   (cfg_duty),
      .wr_mode   (cfg_mode),
      .wr_enable (cfg_enable),
      .sync      (sync_in),
      .pending   (pending_s[g]),
      .pwm       (pwm_out[g])
`ifdef PWM_IRQ_EN
      ,
      .irq       (irq_out[g])
`endif
    );
  end

endmodule

// File: tb/tb_pwm_mc_shadowed.sv
// Self-checking bench for pwm_mc_shadowed: behavioural per-channel model feeds a
// scoreboard every cycle, plus a vector table and hand-written corner sequences.
module tb_pwm_mc_shadowed;
  import pwm_mc_pkg::*;

  localparam int NCH = 7;
  localparam int W   = COUNTER_WIDTH;
  localparam int IW  = 3;

  logic          clk;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [IW-1:0] cfg_ch;
  logic [W-1:0]  cfg_period;
  logic [W-1:0]  cfg_duty;
  logic          cfg_mode;
  logic          cfg_enable;
  logic          sync_in;
  logic [NCH-1:0] pwm_out;
`ifdef PWM_IRQ_EN
  logic [NCH-1:0] irq_out;
`endif

  pwm_mc_shadowed #(
    .NUM_CHANNELS  (NCH),
    .COUNTER_WIDTH (W),
    .CH_IDX_W      (IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .cfg_mode   (cfg_mode),
    .cfg_enable (cfg_enable),
    .sync_in    (sync_in),
    .pwm_out    (pwm_out)
`ifdef PWM_IRQ_EN
    ,
    .irq_out    (irq_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int          m_en[NCH];
  int          m_p[NCH];
  int          m_d[NCH];
  int          m_mode[NCH];
  int          m_anchor[NCH];
  int          pend[NCH];
  pwm_ch_cfg_t p_cfg[NCH];
  logic [NCH-1:0] irq_pend;
  int          cyc;
  int          hi_cnt[NCH];
  int          irq_cnt[NCH];

  typedef struct {
    logic [NCH-1:0] pwm;
    logic [NCH-1:0] irq;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int          ch;
    pwm_ch_cfg_t cfg;
    int          run;
    int          mon;
    int          exp_hi;
  } vec_t;
  vec_t vt[8];

  int total;
  int bad;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int cnt_of(input int i, input int e);
    int k;
    int c;
    k = e - m_anchor[i];
    if (m_mode[i] == 0) begin
      c = k % m_p[i];
    end else begin
      c = k % (2 * m_p[i]);
      if (c >= m_p[i]) c = 2 * m_p[i] - 1 - c;
    end
    return c;
  endfunction

  function automatic logic exp_bit(input int i, input int e);
    if (m_en[i] == 0 || m_p[i] == 0 || e < m_anchor[i]) return 1'b0;
    return (cnt_of(i, e) < m_d[i]);
  endfunction

  function automatic logic bnd(input int i, input int e);
    int k;
    if (m_en[i] == 0) return 1'b0;
    if (m_p[i] == 0) return 1'b1;
    k = e - m_anchor[i];
    if (m_mode[i] == 0) return ((k % m_p[i]) == m_p[i] - 1);
    return ((k % (2 * m_p[i])) == 2 * m_p[i] - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_en[i] = 0; m_p[i] = 0; m_d[i] = 0; m_mode[i] = 0; m_anchor[i] = 0; pend[i] = 0;
      p_cfg[i] = '0;
    end
    irq_pend = '0;
    sbq.delete();
  endtask

  // One clock: predict, push to scoreboard, advance the model, then compare.
  task automatic tick();
    int             e;
    logic           rdy_e;
    logic [NCH-1:0] ep;
    logic [NCH-1:0] nb;
    exp_t           x;
    #1;
    if (int'(cfg_ch) >= NCH) rdy_e = 1'b1;
    else rdy_e = (pend[cfg_ch] == 0);
    check("cfg_ready", int'(cfg_ready), int'(rdy_e));
    e = cyc;
    for (int i = 0; i < NCH; i++) begin
      ep[i] = exp_bit(i, e);
      nb[i] = bnd(i, e);
    end
    x.pwm = ep;
    x.irq = irq_pend;
    sbq.push_back(x);
    irq_pend = nb;
    for (int i = 0; i < NCH; i++) begin
      if (pend[i] != 0 && (m_en[i] == 0 || nb[i] || (sync_in && m_en[i] != 0))) begin
        m_p[i]      = int'(p_cfg[i].period);
        m_d[i]      = int'(p_cfg[i].duty);
        m_mode[i]   = (p_cfg[i].mode == PWM_CENTER) ? 1 : 0;
        m_en[i]     = int'(p_cfg[i].enable);
        m_anchor[i] = e + 1;
        pend[i]     = 0;
      end
    end
    if (sync_in) begin
      for (int i = 0; i < NCH; i++) if (m_en[i] != 0) m_anchor[i] = e + 1;
    end
    if (cfg_valid && rdy_e && int'(cfg_ch) < NCH) begin
      pend[cfg_ch]         = 1;
      p_cfg[cfg_ch].period = cfg_period;
      p_cfg[cfg_ch].duty   = cfg_duty;
      p_cfg[cfg_ch].mode   = pwm_mode_e'(cfg_mode);
      p_cfg[cfg_ch].enable = cfg_enable;
    end
    @(posedge clk);
    #1;
    cyc++;
    x = sbq.pop_front();
    check("pwm_out", int'(pwm_out), int'(x.pwm));
`ifdef PWM_IRQ_EN
    check("irq_out", int'(irq_out), int'(x.irq));
    for (int i = 0; i < NCH; i++) irq_cnt[i] += int'(irq_out[i]);
`endif
    for (int i = 0; i < NCH; i++) hi_cnt[i] += int'(pwm_out[i]);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < NCH; i++) begin
      hi_cnt[i]  = 0;
      irq_cnt[i] = 0;
    end
  endtask

  // Drive one write and return right after the accepting edge.
  task automatic wr(input int ch, input pwm_ch_cfg_t c);
    int n;
    cfg_ch     = IW'(ch);
    cfg_period = c.period;
    cfg_duty   = c.duty;
    cfg_mode   = c.mode;
    cfg_enable = c.enable;
    cfg_valid  = 1'b1;
    n = 0;
    while (ch < NCH && pend[ch] != 0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("wr_timeout", n, 0);
    tick();
    cfg_valid = 1'b0;
  endtask

  function automatic pwm_ch_cfg_t mk(input int p, input int d, input int m, input int en);
    pwm_ch_cfg_t c;
    c.period = W'(p);
    c.duty   = W'(d);
    c.mode   = (m != 0) ? PWM_CENTER : PWM_EDGE;
    c.enable = (en != 0);
    return c;
  endfunction

  task automatic set_vec(input int v, input int ch, input pwm_ch_cfg_t c, input int r, input int mon, input int ex);
    vt[v].ch     = ch;
    vt[v].cfg    = c;
    vt[v].run    = r;
    vt[v].mon    = mon;
    vt[v].exp_hi = ex;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_duty = '0;
    cfg_mode = 1'b0; cfg_enable = 1'b0; sync_in = 1'b0;
    model_reset();
    clr_cnt();

    // Window counts include the first post-accept edge, which is still low.
    set_vec(0, 0, mk(10, 3, 0, 1), 21, 0, 6);
    set_vec(1, 2, mk(8, 4, 1, 1), 33, 2, 16);
    set_vec(2, 4, mk(10, 0, 0, 1), 21, 4, 0);
    set_vec(3, 5, mk(10, 10, 0, 1), 21, 5, 20);
    set_vec(4, 6, mk(0, 5, 0, 1), 21, 6, 0);
    set_vec(5, 3, mk(10, 5, 0, 1), 21, 3, 10);
    set_vec(6, 7, mk(3, 1, 0, 1), 5, -1, 0);
    set_vec(7, 5, mk(10, 15, 0, 1), 25, 5, 25);

    #1;
    check("reset_pwm", int'(pwm_out), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_ready", int'(cfg_ready), 1);
    run(3);

    for (int v = 0; v < 8; v++) begin
      wr(vt[v].ch, vt[v].cfg);
      clr_cnt();
      run(vt[v].run);
      if (vt[v].mon >= 0) check($sformatf("vec%0d_high", v), hi_cnt[vt[v].mon], vt[v].exp_hi);
    end

    // Mid-period duty change on ch1: ready stays low until the boundary.
    wr(1, mk(10, 3, 0, 1));
    run(14);
    wr(1, mk(10, 7, 0, 1));
    check("ch1_ready_held", int'(cfg_ready), 0);
    n = 0;
    while (pend[1] != 0 && n < 30) begin
      tick();
      n++;
    end
    check("ch1_commit_wait", int'(n < 30), 1);
    check("ch1_ready_back", int'(cfg_ready), 1);
    clr_cnt();
    run(10);
    check("ch1_new_duty", hi_cnt[1], 7);

    // Write landing on a boundary cycle commits one period later.
    n = 0;
    while (!bnd(1, cyc) && n < 40) begin
      tick();
      n++;
    end
    check("ch1_bnd_wait", int'(n < 40), 1);
    wr(1, mk(10, 2, 0, 1));
    clr_cnt();
    run(10);
    check("bnd_write_old", hi_cnt[1], 7);
    clr_cnt();
    run(10);
    check("bnd_write_new", hi_cnt[1], 2);

    // Sync with a simultaneous ch3 write: counters realign, write waits.
    run(4);
    cfg_ch = IW'(3); cfg_period = W'(10); cfg_duty = W'(8); cfg_mode = 1'b0;
    cfg_enable = 1'b1; cfg_valid = 1'b1; sync_in = 1'b1;
    tick();
    cfg_valid = 1'b0; sync_in = 1'b0;
    clr_cnt();
    tick();
    check("sync_align", int'({pwm_out[3], pwm_out[0]}), 3);
    run(9);
    check("sync_ch0_high", hi_cnt[0], 3);
    check("sync_ch3_old", hi_cnt[3], 5);
    clr_cnt();
    run(10);
    check("sync_ch3_new", hi_cnt[3], 8);

`ifdef PWM_IRQ_EN
    wr(4, mk(5, 2, 0, 1));
    run(15);
    clr_cnt();
    run(25);
    check("irq_count", irq_cnt[4], 5);
    check("irq_ch4_high", hi_cnt[4], 10);
`endif

    // Asynchronous reset in the middle of a period.
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_pwm", int'(pwm_out), 0);
    check("midreset_ready", int'(cfg_ready), 1);
`ifdef PWM_IRQ_EN
    check("midreset_irq", int'(irq_out), 0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(3);
    wr(0, mk(4, 1, 1, 1));
    clr_cnt();
    run(17);
    check("post_reset_center", hi_cnt[0], 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
